// File: rtl/tcdm_pkg.sv
// Shared index helpers and latency limits for the banked TCDM.
// Byte address -> word address -> (bank, row), with words interleaved across banks.
package tcdm_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 2;

   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                             input int unsigned offs_bits,
                                             input int unsigned num_words);
      return (byte_addr >> offs_bits) % num_words;
   endfunction

   function automatic logic [31:0] bank_idx(input logic [31:0] word,
                                            input int unsigned num_banks);
      return word % num_banks;
   endfunction

   function automatic logic [31:0] row_idx(input logic [31:0] word,
                                           input int unsigned num_banks);
      return word / num_banks;
   endfunction

endpackage

// File: rtl/tcdm_ram_bank.sv
// One TCDM bank: byte-enabled write, registered read-first output.
// The output register only updates on an access, so it is left unreset like the array.
module tcdm_ram_bank #(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_ROWS   = 1024,
   localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ROW_W-1:0]        row,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [NUM_ROWS];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int j = 0; j < DATA_WIDTH/8; j++) begin
            if (we && be[j]) begin
               mem[row][j*8 +: 8] <= wdata[j*8 +: 8];
            end
         end
         rdata <= mem[row];
      end
   end

endmodule

// File: rtl/tcdm_banked_ram.sv
// Multi-port word-interleaved TCDM with per-bank round-robin arbitration.
// Each port carries a granted-bank tag down the response pipe to pick its bank's read data.
module tcdm_banked_ram
   import tcdm_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int NUM_BANKS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_BYTES  = 16384,
   parameter int RD_LATENCY = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_PORTS-1:0]                   req_i,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]                   we_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]                   gnt_o,
   output logic [NUM_PORTS-1:0]                   rvalid_o,
   output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o
);

   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int OFFS_BITS      = $clog2(BYTES_PER_WORD);
   localparam int NUM_WORDS      = NUM_BYTES / BYTES_PER_WORD;
   localparam int NUM_ROWS       = NUM_WORDS / NUM_BANKS;
   localparam int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ROW_W          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("tcdm_banked_ram: RD_LATENCY must be 1 or 2");
   end

   logic [NUM_PORTS-1:0][BANK_W-1:0]         port_bank;
   logic [NUM_PORTS-1:0][ROW_W-1:0]          port_row;
   logic [NUM_BANKS-1:0][PORT_W-1:0]         ptr_q;
   logic [NUM_BANKS-1:0][PORT_W-1:0]         bank_win;
   logic [NUM_BANKS-1:0]                     bank_en;
   logic [NUM_BANKS-1:0]                     bank_we;
   logic [NUM_BANKS-1:0][BYTES_PER_WORD-1:0] bank_be;
   logic [NUM_BANKS-1:0][ROW_W-1:0]          bank_row;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]     bank_wdata;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]     bank_rdata;
   logic [PORT_W-1:0]                        cand;
   logic [NUM_PORTS-1:0]                     valid1_q;
   logic [NUM_PORTS-1:0][BANK_W-1:0]         tag1_q;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     resp1;

   always_comb begin
      port_bank = '0;
      port_row  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         port_bank[k] = BANK_W'(bank_idx(word_addr(32'(addr_i[k]), OFFS_BITS, NUM_WORDS), NUM_BANKS));
         port_row[k]  = ROW_W'(row_idx(word_addr(32'(addr_i[k]), OFFS_BITS, NUM_WORDS), NUM_BANKS));
      end
   end

   // Scan ports starting at the bank pointer; first requester wins.
   always_comb begin
      gnt_o    = '0;
      bank_en  = '0;
      bank_win = '0;
      cand     = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PORT_W'((int'(ptr_q[b]) + i) % NUM_PORTS);
            if (rst_n && !bank_en[b] && req_i[cand] && port_bank[cand] == BANK_W'(b)) begin
               bank_en[b]  = 1'b1;
               bank_win[b] = cand;
            end
         end
         if (bank_en[b]) begin
            gnt_o[bank_win[b]] = 1'b1;
         end
      end
   end

   always_comb begin
      bank_we    = '0;
      bank_be    = '0;
      bank_row   = '0;
      bank_wdata = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_we[b]    = we_i[bank_win[b]];
         bank_be[b]    = be_i[bank_win[b]];
         bank_row[b]   = port_row[bank_win[b]];
         bank_wdata[b] = wdata_i[bank_win[b]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_en[b]) begin
               ptr_q[b] <= (bank_win[b] == PORT_W'(NUM_PORTS - 1)) ? '0 : bank_win[b] + 1'b1;
            end
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      tcdm_ram_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_ROWS   (NUM_ROWS)
      ) u_bank (
         .clk   (clk),
         .en    (bank_en[b]),
         .we    (bank_we[b]),
         .be    (bank_be[b]),
         .row   (bank_row[b]),
         .wdata (bank_wdata[b]),
         .rdata (bank_rdata[b])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid1_q <= '0;
         tag1_q   <= '0;
      end else begin
         valid1_q <= gnt_o;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_o[k]) begin
               tag1_q[k] <= port_bank[k];
            end
         end
      end
   end

   always_comb begin
      resp1 = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         resp1[k] = bank_rdata[tag1_q[k]];
      end
   end

   if (RD_LATENCY == RD_LAT_MAX) begin : g_lat2
      logic [NUM_PORTS-1:0]                 valid2_q;
      logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid2_q <= '0;
            rdata_q  <= '0;
         end else begin
            valid2_q <= valid1_q;
            for (int k = 0; k < NUM_PORTS; k++) begin
               if (valid1_q[k]) begin
                  rdata_q[k] <= resp1[k];
               end
            end
         end
      end

      assign rvalid_o = valid2_q;
      assign rdata_o  = rdata_q;
   end else begin : g_lat1
      // Bank output registers are shared, so each port keeps its own copy of its last response.
      logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] hold_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            hold_q <= '0;
         end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               if (valid1_q[k]) begin
                  hold_q[k] <= resp1[k];
               end
            end
         end
      end

      always_comb begin
         rdata_o = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            rdata_o[k] = valid1_q[k] ? resp1[k] : hold_q[k];
         end
      end

      assign rvalid_o = valid1_q;
   end

endmodule

// File: tb/tb_tcdm_banked_ram.sv
// Directed bench for tcdm_banked_ram: one instance at each read latency, driven by shared stimulus.
module tb_tcdm_banked_ram;

   localparam int NP = 2;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int BW = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NP-1:0]          req;
   logic [NP-1:0]          we;
   logic [NP-1:0][AW-1:0]  addr;
   logic [NP-1:0][BW-1:0]  be;
   logic [NP-1:0][DW-1:0]  wdata;
   logic [NP-1:0]          gnt1, rvalid1, gnt2, rvalid2;
   logic [NP-1:0][DW-1:0]  rdata1, rdata2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tcdm_banked_ram #(.NUM_PORTS(NP), .NUM_BANKS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .NUM_BYTES(16384), .RD_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
      .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1));

   tcdm_banked_ram #(.NUM_PORTS(NP), .NUM_BANKS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .NUM_BYTES(16384), .RD_LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
      .wdata_i(wdata), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic r, input logic [AW-1:0] a,
                           input logic w, input logic [BW-1:0] b, input logic [DW-1:0] d);
      req[p]   = r;
      addr[p]  = a;
      we[p]    = w;
      be[p]    = b;
      wdata[p] = d;
   endtask

   task automatic idle();
      req = '0;
      we  = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      set_port(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
      tick();
      tick();
      checks++; if (gnt1 !== 2'b00) begin failures++; $display("FAIL rst_gnt1 got=%b exp=00", gnt1); end
      checks++; if (gnt2 !== 2'b00) begin failures++; $display("FAIL rst_gnt2 got=%b exp=00", gnt2); end
      checks++; if (rvalid1 !== 2'b00 || rvalid2 !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b/%b exp=00/00", rvalid1, rvalid2); end
      checks++; if (rdata1 !== '0 || rdata2 !== '0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", rdata1, rdata2); end
      idle();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      set_port(0, 1'b1, 16'h0010, 1'b1, 4'hF, 32'hDEADBEEF);
      #1;
      checks++; if (gnt1 !== 2'b01) begin failures++; $display("FAIL wr_gnt got=%b exp=01", gnt1); end
      tick();
      checks++; if (rvalid1 !== 2'b01) begin failures++; $display("FAIL wr_rvalid got=%b exp=01", rvalid1); end
      set_port(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
      #1;
      checks++; if (gnt1 !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b exp=01", gnt1); end
      tick();
      checks++; if (rvalid1 !== 2'b01) begin failures++; $display("FAIL rd_rvalid got=%b exp=01", rvalid1); end
      checks++; if (rdata1[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rdata1[0]); end
      idle();
      tick();
      checks++; if (rvalid1 !== 2'b00) begin failures++; $display("FAIL idle_rvalid got=%b exp=00", rvalid1); end
      checks++; if (rdata1[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL hold_data got=%h exp=deadbeef", rdata1[0]); end
   endtask

   task automatic test_byte_enable();
      set_port(0, 1'b1, 16'h0020, 1'b1, 4'hF, 32'h11223344);
      tick();
      set_port(0, 1'b1, 16'h0020, 1'b1, 4'h5, 32'hAABBCCDD);
      tick();
      checks++; if (rvalid1 !== 2'b01) begin failures++; $display("FAIL be_wr_rvalid got=%b exp=01", rvalid1); end
      checks++; if (rdata1[0] !== 32'h11223344) begin failures++; $display("FAIL be_read_first got=%h exp=11223344", rdata1[0]); end
      set_port(0, 1'b1, 16'h0020, 1'b0, 4'h0, 32'h0);
      tick();
      checks++; if (rdata1[0] !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rdata1[0]); end
      set_port(0, 1'b1, 16'h0020, 1'b1, 4'h0, 32'hFFFFFFFF);
      tick();
      checks++; if (rvalid1 !== 2'b01) begin failures++; $display("FAIL be0_rvalid got=%b exp=01", rvalid1); end
      set_port(0, 1'b1, 16'h0020, 1'b0, 4'h0, 32'h0);
      tick();
      checks++; if (rdata1[0] !== 32'h11BB33DD) begin failures++; $display("FAIL be0_noop got=%h exp=11bb33dd", rdata1[0]); end
      idle();
      tick();
   endtask

   task automatic test_arbitration();
      logic [1:0]  exp_g [4];
      logic [31:0] exp_d;
      int          p;
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      set_port(0, 1'b1, 16'h0004, 1'b1, 4'hF, 32'hA0A0A0A0);
      tick();
      idle();
      set_port(1, 1'b1, 16'h0014, 1'b1, 4'hF, 32'h51515151);
      tick();
      set_port(0, 1'b1, 16'h0004, 1'b0, 4'h0, 32'h0);
      set_port(1, 1'b1, 16'h0014, 1'b0, 4'h0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (gnt1 !== exp_g[c]) begin failures++; $display("FAIL arb_gnt[%0d] got=%b exp=%b", c, gnt1, exp_g[c]); end
         tick();
         checks++; if (rvalid1 !== exp_g[c]) begin failures++; $display("FAIL arb_rvalid[%0d] got=%b exp=%b", c, rvalid1, exp_g[c]); end
         p = c % 2;
         exp_d = (p == 0) ? 32'hA0A0A0A0 : 32'h51515151;
         checks++; if (rdata1[p] !== exp_d) begin failures++; $display("FAIL arb_data[%0d] got=%h exp=%h", c, rdata1[p], exp_d); end
      end
      idle();
      tick();
   endtask

   task automatic test_parallel();
      set_port(0, 1'b1, 16'h0000, 1'b1, 4'hF, 32'h0BADF00D);
      tick();
      set_port(0, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
      set_port(1, 1'b1, 16'h0004, 1'b0, 4'h0, 32'h0);
      #1;
      checks++; if (gnt1 !== 2'b11) begin failures++; $display("FAIL par_gnt got=%b exp=11", gnt1); end
      tick();
      checks++; if (rvalid1 !== 2'b11) begin failures++; $display("FAIL par_rvalid got=%b exp=11", rvalid1); end
      checks++; if (rdata1[0] !== 32'h0BADF00D) begin failures++; $display("FAIL par_data0 got=%h exp=0badf00d", rdata1[0]); end
      checks++; if (rdata1[1] !== 32'hA0A0A0A0) begin failures++; $display("FAIL par_data1 got=%h exp=a0a0a0a0", rdata1[1]); end
      idle();
      tick();
   endtask

   task automatic test_addr_wrap();
      // 0x4013 wraps to word 4 (0x0010); 0x8007 wraps to word 1 (0x0004).
      set_port(0, 1'b1, 16'h4013, 1'b0, 4'h0, 32'h0);
      set_port(1, 1'b1, 16'h8007, 1'b0, 4'h0, 32'h0);
      #1;
      checks++; if (gnt1 !== 2'b11) begin failures++; $display("FAIL wrap_gnt got=%b exp=11", gnt1); end
      tick();
      checks++; if (rdata1[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL wrap_data0 got=%h exp=deadbeef", rdata1[0]); end
      checks++; if (rdata1[1] !== 32'hA0A0A0A0) begin failures++; $display("FAIL wrap_data1 got=%h exp=a0a0a0a0", rdata1[1]); end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] a [3];
      logic [31:0] d [3];
      a = '{16'h0010, 16'h0020, 16'h0000};
      d = '{32'hDEADBEEF, 32'h11BB33DD, 32'h0BADF00D};
      for (int c = 0; c < 5; c++) begin
         if (c < 3) set_port(0, 1'b1, a[c], 1'b0, 4'h0, 32'h0);
         else       idle();
         #1;
         checks++; if (gnt2[0] !== (c < 3)) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", c, gnt2[0], (c < 3)); end
         tick();
         checks++; if (rvalid1[0] !== (c < 3)) begin failures++; $display("FAIL b2b_rvalid_l1[%0d] got=%b exp=%b", c, rvalid1[0], (c < 3)); end
         if (c < 3) begin
            checks++; if (rdata1[0] !== d[c]) begin failures++; $display("FAIL b2b_data_l1[%0d] got=%h exp=%h", c, rdata1[0], d[c]); end
         end
         checks++; if (rvalid2[0] !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL b2b_rvalid_l2[%0d] got=%b exp=%b", c, rvalid2[0], (c >= 1 && c <= 3)); end
         if (c >= 1 && c <= 3) begin
            checks++; if (rdata2[0] !== d[c-1]) begin failures++; $display("FAIL b2b_data_l2[%0d] got=%h exp=%h", c, rdata2[0], d[c-1]); end
         end
      end
      checks++; if (rdata2[0] !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_hold_l2 got=%h exp=0badf00d", rdata2[0]); end
   endtask

   task automatic test_reset_inflight();
      set_port(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
      tick();
      rst_n = 1'b0;
      set_port(0, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
      set_port(1, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
      #1;
      checks++; if (gnt1 !== 2'b00 || gnt2 !== 2'b00) begin failures++; $display("FAIL rsti_gnt got=%b/%b exp=00/00", gnt1, gnt2); end
      tick();
      checks++; if (rvalid1 !== 2'b00 || rvalid2 !== 2'b00) begin failures++; $display("FAIL rsti_rvalid got=%b/%b exp=00/00", rvalid1, rvalid2); end
      checks++; if (rdata1 !== '0 || rdata2 !== '0) begin failures++; $display("FAIL rsti_rdata got=%h/%h exp=0", rdata1, rdata2); end
      rst_n = 1'b1;
      #1;
      checks++; if (gnt1 !== 2'b01) begin failures++; $display("FAIL rsti_ptr got=%b exp=01", gnt1); end
      tick();
      checks++; if (rdata1[0] !== 32'h0BADF00D) begin failures++; $display("FAIL rsti_post_data got=%h exp=0badf00d", rdata1[0]); end
      checks++; if (rvalid2 !== 2'b00) begin failures++; $display("FAIL rsti_l2_flushed got=%b exp=00", rvalid2); end
      idle();
      set_port(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
      tick();
      idle();
      checks++; if (rdata1[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rsti_mem_kept got=%h exp=deadbeef", rdata1[0]); end
      tick();
      checks++; if (rvalid2 !== 2'b01 || rdata2[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rsti_mem_kept_l2 got=%b/%h exp=01/deadbeef", rvalid2, rdata2[0]); end
   endtask

   initial begin
      req   = '0;
      we    = '0;
      addr  = '0;
      be    = '0;
      wdata = '0;
      rst_n = 1'b0;
      test_reset();
      test_write_read();
      test_byte_enable();
      test_arbitration();
      test_parallel();
      test_addr_wrap();
      test_back_to_back();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
